// File: rtl/shift_deserializer_if.sv
// Bundle of the serial input side and the parallel word output side of shift_deserializer.
// The producer/consumer uses the master modport; the receiver uses the slave modport.
interface shift_deserializer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             serial_in;
  logic             bit_valid;
  logic             start;
  logic             dir;
  logic             clr;
  logic             word_ready;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             busy;
  logic             overrun;

  modport master (
    output serial_in, bit_valid, start, dir, clr, word_ready,
    input  word_out, word_valid, busy, overrun
  );

  modport slave (
    input  serial_in, bit_valid, start, dir, clr, word_ready,
    output word_out, word_valid, busy, overrun
  );
endinterface

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: reassembles WIDTH-bit frames in either bit order and
// presents them through a double-buffered valid/ready port with a sticky overrun flag.
module shift_deserializer #(
  parameter int unsigned WIDTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  shift_deserializer_if.slave  bus
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic             dir_eff;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] shifted;
  logic             complete;

  // A start clears the frame, so the first bit shifts into a zeroed register with the new dir.
  assign dir_eff = bus.start ? bus.dir : dir_q;
  assign base    = bus.start ? '0 : shift_q;
  assign shifted = dir_eff ? {bus.serial_in, base[WIDTH-1:1]}
                           : {base[WIDTH-2:0], bus.serial_in};

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    count_d  = count_q;
    dir_d    = dir_q;
    complete = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StShift;
          dir_d   = bus.dir;
          shift_d = '0;
          count_d = '0;
          if (bus.bit_valid) begin
            shift_d = shifted;
            count_d = CntW'(1);
          end
        end
      end
      StShift: begin
        if (bus.start) begin
          dir_d   = bus.dir;
          shift_d = '0;
          count_d = '0;
          if (bus.bit_valid) begin
            shift_d = shifted;
            count_d = CntW'(1);
          end
        end else if (bus.bit_valid) begin
          shift_d = shifted;
          if (count_q == CntW'(WIDTH - 1)) begin
            complete = 1'b1;
            count_d  = '0;
            state_d  = StIdle;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    word_d  = word_q;
    valid_d = valid_q && !bus.word_ready;
    ovr_d   = bus.clr ? 1'b0 : ovr_q;
    if (complete) begin
      if (!valid_q || bus.word_ready) begin
        word_d  = shifted;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;  // set beats a same-edge clr
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      count_q <= '0;
      dir_q   <= 1'b0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.word_out   = word_q;
  assign bus.word_valid = valid_q;
  assign bus.busy       = (state_q == StShift);
  assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_shift_deserializer.sv
// Scoreboard bench for shift_deserializer (WIDTH = 4): expected words are queued as frames
// are driven and compared whenever the DUT hands a word over.
module tb_shift_deserializer;
  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  shift_deserializer_if #(.WIDTH(W)) sif ();

  shift_deserializer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] sb[$];
  int busy_cnt  = 0;
  int valid_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transfer happens on the next rising edge; sample half a cycle earlier.
  always @(negedge clk) begin
    if (sif.busy === 1'b1) busy_cnt++;
    if (sif.word_valid === 1'b1) valid_cnt++;
    if (sif.word_valid === 1'b1 && sif.word_ready === 1'b1) begin
      check("sb_has_entry", (sb.size() != 0), 1);
      if (sb.size() != 0) check("word_out", sif.word_out, sb.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  // seq[W-1] is the first bit on the wire; dir is flipped after start to show it is latched.
  task automatic frame(input logic d, input logic [W-1:0] seq, input int gap,
                       input bit push, input bit chk_valid);
    if (push) sb.push_back(d ? rev(seq) : seq);
    for (int i = 0; i < W; i++) begin
      sif.start     = (i == 0);
      sif.dir       = (i == 0) ? d : ~d;
      sif.bit_valid = 1'b1;
      sif.serial_in = seq[W-1-i];
      step();
      sif.start     = 1'b0;
      sif.bit_valid = 1'b0;
      if (i < W - 1) begin
        check("busy_mid", sif.busy, 1);
        if (chk_valid) check("no_early_valid", sif.word_valid, 0);
        for (int g = 0; g < gap; g++) begin
          step();
          check("busy_gap", sif.busy, 1);
          if (chk_valid) check("no_early_valid_gap", sif.word_valid, 0);
        end
      end else begin
        check("busy_end", sif.busy, 0);
      end
    end
  endtask

  int b0, v0;

  initial begin
    sif.serial_in  = 1'b0;
    sif.bit_valid  = 1'b0;
    sif.start      = 1'b0;
    sif.dir        = 1'b0;
    sif.clr        = 1'b0;
    sif.word_ready = 1'b1;
    #3;
    check("rst_word_out", sif.word_out, 0);
    check("rst_valid", sif.word_valid, 0);
    check("rst_busy", sif.busy, 0);
    check("rst_overrun", sif.overrun, 0);
    #9 rst = 1'b1;
    step();

    // MSB-first
    b0 = busy_cnt; v0 = valid_cnt;
    frame(1'b0, 4'b1011, 0, 1'b1, 1'b1);
    step(); step();
    check("msb_busy_cycles", busy_cnt - b0, 3);
    check("msb_valid_cycles", valid_cnt - v0, 1);
    check("msb_valid_low", sif.word_valid, 0);

    // LSB-first: wire order 1,0,0,0 -> 4'b0001
    frame(1'b1, 4'b1000, 0, 1'b1, 1'b1);
    step();

    // Gapped bits
    frame(1'b0, 4'b0110, 2, 1'b1, 1'b1);
    step();

    // Back-to-back frames at full rate
    frame(1'b0, 4'b1001, 0, 1'b1, 1'b1);
    frame(1'b1, 4'b1101, 0, 1'b1, 1'b0);
    step();
    check("b2b_idle", sif.word_valid, 0);

    // Backpressure and overrun
    sif.word_ready = 1'b0;
    frame(1'b0, 4'b0010, 0, 1'b1, 1'b1);
    check("bp_first_valid", sif.word_valid, 1);
    check("bp_no_overrun", sif.overrun, 0);
    frame(1'b0, 4'b1111, 0, 1'b0, 1'b0);
    check("bp_word_held", sif.word_out, 4'b0010);
    check("bp_overrun", sif.overrun, 1);
    step();
    check("bp_overrun_sticky", sif.overrun, 1);
    sif.clr = 1'b1;
    step();
    sif.clr = 1'b0;
    check("clr_overrun", sif.overrun, 0);
    check("clr_keeps_valid", sif.word_valid, 1);
    sif.word_ready = 1'b1;
    step();
    check("bp_drained", sif.word_valid, 0);

    // Abort: two bits then restart
    sif.start = 1'b1; sif.dir = 1'b0; sif.bit_valid = 1'b1; sif.serial_in = 1'b1;
    step();
    sif.start = 1'b0;
    step();
    sif.bit_valid = 1'b0;
    check("abort_busy", sif.busy, 1);
    frame(1'b0, 4'b1100, 0, 1'b1, 1'b1);
    step();

    // Reset mid-frame
    sif.start = 1'b1; sif.dir = 1'b1; sif.bit_valid = 1'b1; sif.serial_in = 1'b1;
    step();
    sif.start = 1'b0; sif.serial_in = 1'b0;
    step();
    sif.bit_valid = 1'b0;
    check("pre_rst_busy", sif.busy, 1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_busy", sif.busy, 0);
    check("mid_rst_valid", sif.word_valid, 0);
    check("mid_rst_word", sif.word_out, 0);
    check("mid_rst_overrun", sif.overrun, 0);
    #2 rst = 1'b1;
    step();
    sif.bit_valid = 1'b1; sif.serial_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("bare_bit_valid", sif.word_valid, 0);
      check("bare_bit_busy", sif.busy, 0);
    end
    sif.bit_valid = 1'b0;
    step();
    frame(1'b0, 4'b0101, 0, 1'b1, 1'b1);
    repeat (3) step();

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_deserializer.md
# shift_deserializer

Serial-to-parallel receiver forming the far end of the universal shift register link. The shift register parallel-loads a word and shifts it out one bit per cycle, left or right. This block samples that bit stream, reassembles WIDTH-bit words in either bit order, and presents each word on a valid/ready output port. A holding register double-buffers the output so the next frame can start while the previous word waits. Overrun is reported when the consumer stalls.

## Interface
- WIDTH, 4, word length in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- serial_in  input  1  serial data bit
- bit_valid  input  1  serial_in is a valid bit on this edge
- start  input  1  frame start; latches dir and clears the bit count
- dir  input  1  bit order: 0 = MSB-first (shift left, new bit enters bit 0); 1 = LSB-first (shift right, new bit enters bit WIDTH-1)
- clr  input  1  clears overrun
- word_ready  input  1  consumer accepts word_out
- word_out  output  WIDTH  assembled word, registered
- word_valid  output  1  word_out holds an unconsumed word
- busy  output  1  a frame is in progress (state SHIFT)
- overrun  output  1  sticky flag: a completed word was dropped

## Operation
- Internal state: a shift register, a bit counter of width clog2(WIDTH+1), a latched dir, and a two-state FSM with states IDLE and SHIFT.
- IDLE:
  - bit_valid without start is ignored.
  - start latches dir and loads count = 0. If bit_valid is also high, the bit shifts in and count = 1. The FSM moves to SHIFT.
- SHIFT, start low, bit_valid high: shift in the bit using the latched dir; count increments.
- Completing bit: this is the bit_valid edge where count == WIDTH-1.
  - The fully shifted value is offered to the holding register.
  - count clears and the FSM returns to IDLE. Every frame needs a new start.
- SHIFT, start high: the partial frame is discarded and the frame restarts exactly as from IDLE. start has priority over completion.
- SHIFT, bit_valid low: hold; count and the shift register are unchanged.
- Holding register, at a completing edge:
  - Loads if word_valid == 0, or if word_valid && word_ready on the same edge (the old word is consumed and the new one replaces it; word_valid stays 1).
  - Otherwise the new word is dropped, word_out and word_valid are unchanged, and overrun is set.
- Handshake: a transfer occurs on the edge where word_valid && word_ready. word_valid clears on that edge unless a new word loads on it. word_out is stable whenever word_valid && !word_ready.
- Overrun flag: stays set until clr or reset. If a set and clr happen on the same edge, set wins.
- Reset (rst low, asynchronous, any time including mid-frame):
  - word_out = 0, word_valid = 0, busy = 0, overrun = 0.
  - count = 0, shift register = 0, latched dir = 0, state = IDLE.
  - No partial word survives reset.

## Timing
- All outputs are registered and change only on rising clk, except on asynchronous reset assertion.
- Latency: word_valid rises on the edge that samples the completing bit, so it is visible that cycle. Minimum frame is WIDTH consecutive bit_valid cycles, with the first bit coincident with start.
- busy rises on the start edge and falls on the completing edge.
- Back-to-back frames: a start coincident with the completing bit is treated as a restart, so the completing bit is not taken. The earliest new start is the edge after completion. With word_ready held high, throughput is one word per WIDTH cycles.
- Reset deassertion is synchronized externally; the block makes no requirement on the first edge after release.

## Test plan
All scenarios use WIDTH = 4.
- MSB-first: dir = 0; start with bit_valid; bits 1,0,1,1 on consecutive cycles; word_ready = 1 -> word_out = 4'b1011, word_valid high for exactly one cycle, busy high for 3 cycles.
- LSB-first: dir = 1; bits 1,0,0,0 -> word_out = 4'b0001. Toggling dir mid-frame has no effect.
- Gapped bits: bits 0,1,1,0 with 2 idle cycles between each -> word_out = 4'b0110; busy held through the gaps; no valid before the 4th bit.
- Backpressure and overrun: word_ready = 0; frame 0010, then frame 1111 -> word_out stays 4'b0010, overrun = 1. Pulse clr -> overrun = 0. Raise word_ready -> one transfer, then word_valid = 0.
- Abort: start, bits 1,1, start again, bits 1,1,0,0 -> a single word, 4'b1100, with no intermediate valid.
- Reset mid-frame: drive rst low between clock edges after 2 bits -> all outputs 0 immediately. After release, a bare bit_valid (no start) produces no word.
